// File: rtl/configurable_serial_transmitter.sv
// Configurable UART transmitter with a small word FIFO in front of the
// frame serializer. Frame: start, DATA_BITS LSB first, optional parity, stop bits.
module configurable_serial_transmitter #(
    parameter int unsigned CLOCK_HZ   = 48000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_data_available,
    output logic                          tx_ready,
    output logic                          serial_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CLOCKS_PER_BIT = CLOCK_HZ / BAUD;
    localparam int unsigned PTR_W          = $clog2(FIFO_DEPTH);
    localparam int unsigned COUNT_W        = PTR_W + 1;
    localparam int unsigned CNT_W          = 16;
    localparam int unsigned IDX_W          = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP
    } state_t;

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_reg;

    logic                 push_c;
    logic                 pop_c;
    logic                 bit_end_c;
    logic                 frame_end_c;
    logic                 active_next_c;
    logic                 parity_c;
    logic [DATA_BITS-1:0] head_c;
    logic [COUNT_W-1:0]   count_next_c;

    // Handshake, pop decision and next-cycle FIFO occupancy
    always_comb begin
        bit_end_c     = (bit_cnt == CNT_W'(CLOCKS_PER_BIT - 1));
        frame_end_c   = (state == STOP) && bit_end_c && (stop_idx == 1'(STOP_BITS - 1));
        push_c        = tx_data_available && tx_ready;
        pop_c         = (fifo_count != '0) && ((state == IDLE) || frame_end_c);
        head_c        = fifo_mem[rd_ptr];
        parity_c      = (PARITY == 1) ? ~(^head_c) : (^head_c);
        active_next_c = pop_c || !((state == IDLE) || frame_end_c);
        count_next_c  = fifo_count;
        if (push_c && !pop_c) begin
            count_next_c = fifo_count + COUNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_next_c = fifo_count - COUNT_W'(1);
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clock) begin
        if (!reset && push_c) begin
            fifo_mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers, occupancy and registered status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_next_c;
            tx_ready   <= (count_next_c != COUNT_W'(FIFO_DEPTH));
            tx_busy    <= active_next_c || (count_next_c != '0);
        end
    end

    // Frame serializer FSM with registered line output
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            serial_tx  <= 1'b1;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt   <= '0;
                    serial_tx <= 1'b1;
                    if (pop_c) begin
                        shift_reg  <= head_c;
                        parity_reg <= parity_c;
                        state      <= START;
                        serial_tx  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_c) begin
                        bit_cnt   <= '0;
                        bit_idx   <= '0;
                        state     <= DATA;
                        serial_tx <= shift_reg[0];
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_c) begin
                        bit_cnt <= '0;
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            if (PARITY != 0) begin
                                state     <= PARITY_BIT;
                                serial_tx <= parity_reg;
                            end else begin
                                state     <= STOP;
                                serial_tx <= 1'b1;
                                stop_idx  <= 1'b0;
                            end
                        end else begin
                            bit_idx   <= bit_idx + IDX_W'(1);
                            shift_reg <= shift_reg >> 1;
                            serial_tx <= shift_reg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                PARITY_BIT: begin
                    if (bit_end_c) begin
                        bit_cnt   <= '0;
                        state     <= STOP;
                        serial_tx <= 1'b1;
                        stop_idx  <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end_c) begin
                        bit_cnt <= '0;
                        if (frame_end_c) begin
                            if (pop_c) begin
                                shift_reg  <= head_c;
                                parity_reg <= parity_c;
                                state      <= START;
                                serial_tx  <= 1'b0;
                            end else begin
                                state     <= IDLE;
                                serial_tx <= 1'b1;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    serial_tx <= 1'b1;
                    bit_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_configurable_serial_transmitter.sv
// Directed bench for configurable_serial_transmitter: three parameterisations
// sharing one clock (8N1 @16 clk/bit, 7E2 @4 clk/bit, 8O1 @4 clk/bit).
module tb_configurable_serial_transmitter;

    logic clock;
    logic reset;

    logic [7:0] a_data;
    logic       a_av, a_ready, a_tx, a_busy;
    logic [2:0] a_count;

    logic [6:0] b_data;
    logic       b_av, b_ready, b_tx, b_busy;
    logic [2:0] b_count;

    logic [7:0] c_data;
    logic       c_av, c_ready, c_tx, c_busy;
    logic [2:0] c_count;

    int n_compared;
    int n_mismatched;
    int cyc;

    bit         mon_en;
    int         mon_start[$];
    logic [8:0] mon_word[$];

    configurable_serial_transmitter #(
        .CLOCK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clock(clock), .reset(reset), .tx_data(a_data), .tx_data_available(a_av),
        .tx_ready(a_ready), .serial_tx(a_tx), .tx_busy(a_busy), .fifo_count(a_count)
    );

    configurable_serial_transmitter #(
        .CLOCK_HZ(4), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clock(clock), .reset(reset), .tx_data(b_data), .tx_data_available(b_av),
        .tx_ready(b_ready), .serial_tx(b_tx), .tx_busy(b_busy), .fifo_count(b_count)
    );

    configurable_serial_transmitter #(
        .CLOCK_HZ(4), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_c (
        .clock(clock), .reset(reset), .tx_data(c_data), .tx_data_available(c_av),
        .tx_ready(c_ready), .serial_tx(c_tx), .tx_busy(c_busy), .fifo_count(c_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Time guard so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line_of(input int sel);
        case (sel)
            0:       return a_tx;
            1:       return b_tx;
            default: return c_tx;
        endcase
    endfunction

    // Called at the first negedge of a start bit; samples each bit at its
    // first, middle and last clock so bit length errors also show up.
    task automatic expect_frame(input int sel, input int cpb, input int nbits,
                                input logic [15:0] exp, input string tag);
        logic [15:0] f, m, l;
        f = '0; m = '0; l = '0;
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < cpb; j++) begin
                if (j == 0)       f[i] = line_of(sel);
                if (j == cpb / 2) m[i] = line_of(sel);
                if (j == cpb - 1) l[i] = line_of(sel);
                @(negedge clock);
            end
        end
        check({tag, "_first"}, 32'(f), 32'(exp));
        check({tag, "_mid"},   32'(m), 32'(exp));
        check({tag, "_last"},  32'(l), 32'(exp));
    endtask

    task automatic wait_low(input int sel, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (line_of(sel) == 1'b0) begin
                ok = 1'b1;
                return;
            end
            @(negedge clock);
        end
    endtask

    // Frame decoder for instance A (8N1, 16 clocks per bit)
    initial begin : a_monitor
        logic [8:0] w;
        forever begin
            @(negedge clock);
            if (mon_en && !reset && a_tx == 1'b0) begin
                mon_start.push_back(cyc);
                repeat (8) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clock);
                    w[i] = a_tx;
                end
                repeat (16) @(negedge clock);
                w[8] = a_tx;
                mon_word.push_back(w);
                repeat (7) @(negedge clock);
            end
        end
    end

    initial begin : main
        bit ok;
        int lows;
        logic [7:0] fill_words [5];
        fill_words[0] = 8'h11; fill_words[1] = 8'h22; fill_words[2] = 8'h33;
        fill_words[3] = 8'h44; fill_words[4] = 8'h55;

        n_compared = 0; n_mismatched = 0; cyc = 0; mon_en = 1'b0;
        reset = 1'b1;
        a_data = '0; a_av = 1'b0;
        b_data = '0; b_av = 1'b0;
        c_data = '0; c_av = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_tx",    32'(a_tx),    32'd1);
        check("rst_count", 32'(a_count), 32'd0);
        check("rst_ready", 32'(a_ready), 32'd1);
        check("rst_busy",  32'(a_busy),  32'd0);
        check("rst_tx_b",  32'(b_tx),    32'd1);
        check("rst_tx_c",  32'(c_tx),    32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 8N1 0xA5: latency and exact bit timing
        a_data = 8'hA5; a_av = 1'b1;
        @(negedge clock);
        a_av = 1'b0;
        check("a5_n_tx",    32'(a_tx),    32'd1);
        check("a5_n_count", 32'(a_count), 32'd1);
        check("a5_n_busy",  32'(a_busy),  32'd1);
        @(negedge clock);
        check("a5_n1_tx",    32'(a_tx),    32'd0);
        check("a5_n1_count", 32'(a_count), 32'd0);
        expect_frame(0, 16, 10, 16'b11_0100_1010, "a5_frame");
        check("a5_end_tx",   32'(a_tx),   32'd1);
        check("a5_end_busy", 32'(a_busy), 32'd0);
        repeat (4) @(negedge clock);

        // Five back-to-back words, then hold request while full
        mon_en = 1'b1;
        a_av = 1'b1;
        a_data = fill_words[0];
        @(negedge clock);
        check("fill_c1", 32'(a_count), 32'd1);
        a_data = fill_words[1];
        @(negedge clock);
        check("fill_simul_count", 32'(a_count), 32'd1);
        check("fill_start_low",   32'(a_tx),    32'd0);
        a_data = fill_words[2];
        @(negedge clock);
        a_data = fill_words[3];
        @(negedge clock);
        check("fill_c3",       32'(a_count), 32'd3);
        check("fill_c3_ready", 32'(a_ready), 32'd1);
        a_data = fill_words[4];
        @(negedge clock);
        check("fill_c4",       32'(a_count), 32'd4);
        check("fill_c4_ready", 32'(a_ready), 32'd0);
        a_data = 8'h66;
        repeat (3) @(negedge clock);
        check("full_hold_count", 32'(a_count), 32'd4);
        check("full_hold_ready", 32'(a_ready), 32'd0);
        a_av = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (!a_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("fill_drain_done", 32'(ok), 32'd1);
        repeat (4) @(negedge clock);
        mon_en = 1'b0;
        check("fill_frames", 32'(mon_word.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < mon_word.size())
                check($sformatf("fill_word%0d", i), 32'(mon_word[i]), 32'({1'b1, fill_words[i]}));
            if (i < 4 && i + 1 < mon_start.size())
                check($sformatf("fill_gap%0d", i), 32'(mon_start[i+1] - mon_start[i]), 32'd160);
        end

        // Reset 40 cycles into a frame with two words queued, plus same-cycle enqueue
        a_av = 1'b1; a_data = 8'h5A;
        @(negedge clock);
        a_data = 8'h3C;
        @(negedge clock);
        a_data = 8'h0F;
        @(negedge clock);
        a_av = 1'b0;
        check("rst_pre_count", 32'(a_count), 32'd2);
        check("rst_pre_tx",    32'(a_tx),    32'd0);
        repeat (39) @(negedge clock);
        reset = 1'b1; a_av = 1'b1; a_data = 8'h77;
        @(negedge clock);
        check("rst_mid_tx",    32'(a_tx),    32'd1);
        check("rst_mid_count", 32'(a_count), 32'd0);
        check("rst_mid_busy",  32'(a_busy),  32'd0);
        check("rst_mid_ready", 32'(a_ready), 32'd1);
        reset = 1'b0; a_av = 1'b0;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (a_tx == 1'b0) lows++;
        end
        check("rst_no_frames", 32'(lows), 32'd0);
        check("rst_idle_busy", 32'(a_busy), 32'd0);

        // 7E2 0x03: parity 0, two stop bits
        b_data = 7'h03; b_av = 1'b1;
        @(negedge clock);
        b_av = 1'b0;
        wait_low(1, 10, ok);
        check("b_start_seen", 32'(ok), 32'd1);
        expect_frame(1, 4, 11, 16'b110_0000_0110, "b_frame");
        check("b_end_busy", 32'(b_busy), 32'd0);

        // 8O1 0x00 then 0xFF back-to-back: parity 1 both times, no gap
        c_av = 1'b1; c_data = 8'h00;
        @(negedge clock);
        c_data = 8'hFF;
        @(negedge clock);
        c_av = 1'b0;
        wait_low(2, 10, ok);
        check("c_start_seen", 32'(ok), 32'd1);
        expect_frame(2, 4, 11, 16'b110_0000_0000, "c_frame00");
        expect_frame(2, 4, 11, 16'b111_1111_1110, "c_frameff");
        check("c_end_tx",   32'(c_tx),   32'd1);
        check("c_end_busy", 32'(c_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
